// File: rtl/axi_rd_arbiter_pkg.sv
// rtl/axi_rd_arbiter_pkg.sv - state encodings and AXI field widths for the read arbiter
package axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int LOCK_W  = 2;
  localparam int CACHE_W = 4;
  localparam int PROT_W  = 3;
  localparam int QOS_W   = 4;
  localparam int RESP_W  = 2;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// rtl/axi_rd_arbiter_if.sv - AXI4 read-only channel bundle (AR + R)
interface axi_rd_arbiter_if #(
  parameter int ID_W     = 1,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARUSER_W = 1,
  parameter int RUSER_W  = 4
);
  import axi_rd_arb_pkg::*;

  logic [ID_W-1:0]     ARID;
  logic [ADDR_W-1:0]   ARADDR;
  logic [LEN_W-1:0]    ARLEN;
  logic [SIZE_W-1:0]   ARSIZE;
  logic [BURST_W-1:0]  ARBURST;
  logic [LOCK_W-1:0]   ARLOCK;
  logic [CACHE_W-1:0]  ARCACHE;
  logic [PROT_W-1:0]   ARPROT;
  logic [QOS_W-1:0]    ARQOS;
  logic [ARUSER_W-1:0] ARUSER;
  logic                ARVALID;
  logic                ARREADY;

  logic [ID_W-1:0]     RID;
  logic [DATA_W-1:0]   RDATA;
  logic [RESP_W-1:0]   RRESP;
  logic                RLAST;
  logic [RUSER_W-1:0]  RUSER;
  logic                RVALID;
  logic                RREADY;

  // Side that issues read requests (cache engine, or the arbiter toward memory).
  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARUSER, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RUSER, RVALID,
    output RREADY
  );

  // Side that accepts read requests and returns data.
  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARUSER, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RUSER, RVALID,
    input  RREADY
  );

endinterface

// File: rtl/axi_rd_arbiter_rr.sv
// rtl/axi_rd_arbiter_rr.sv - two-way pick; AXI_RD_ARB_FIXED_PRIO_EN selects S1-wins fixed priority
module rr_arbiter_2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       pick_o
);

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
  // History is irrelevant here; data loads always beat instruction fetch.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  // Fixed priority: S1 whenever it asks.
  always_comb begin
    pick_o = req_i[1];
  end
`else
  // Round-robin: a lone requester wins, a tie goes to whoever did not go last.
  always_comb begin
    pick_o = 1'b0;
    case (req_i)
      2'b01:   pick_o = 1'b0;
      2'b10:   pick_o = 1'b1;
      2'b11:   pick_o = ~last_grant_i;
      default: pick_o = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - shares one AXI4 read master between ifetch (S0) and dload (S1); AXI_RD_ARB_FIXED_PRIO_EN for fixed priority
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 32,
  parameter int C_M_AXI_ARUSER_WIDTH    = 1,
  parameter int C_M_AXI_RUSER_WIDTH     = 4
) (
  input  logic       CLK,
  input  logic       RST,
  axi_rd_arbiter_if.slave  S0_AXI,
  axi_rd_arbiter_if.slave  S1_AXI,
  axi_rd_arbiter_if.master M_AXI,
  output logic [1:0] GRANT,
  output logic       BUSY
);

  // Widths are carried by the interface instances; these document the bus shape.
  localparam int unused_param_sum = C_M_AXI_THREAD_ID_WIDTH + C_M_AXI_ADDR_WIDTH +
                                    C_M_AXI_DATA_WIDTH + C_M_AXI_ARUSER_WIDTH + C_M_AXI_RUSER_WIDTH;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_grant_q, last_grant_d;
  logic   pick;
  logic   ar_valid;
  logic   r_ready;

  rr_arbiter_2 u_pick (
    .req_i        ({S1_AXI.ARVALID, S0_AXI.ARVALID}),
    .last_grant_i (last_grant_q),
    .pick_o       (pick)
  );

  // State, owner and round-robin history; last_grant resets to S1 so S0 takes the first tie.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next state plus the AR/R steering toward the current owner; everything idles at zero.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;

    ar_valid = grant_q ? S1_AXI.ARVALID : S0_AXI.ARVALID;
    r_ready  = grant_q ? S1_AXI.RREADY  : S0_AXI.RREADY;

    M_AXI.ARID    = '0;
    M_AXI.ARADDR  = '0;
    M_AXI.ARLEN   = '0;
    M_AXI.ARSIZE  = '0;
    M_AXI.ARBURST = '0;
    M_AXI.ARLOCK  = '0;
    M_AXI.ARCACHE = '0;
    M_AXI.ARPROT  = '0;
    M_AXI.ARQOS   = '0;
    M_AXI.ARUSER  = '0;
    M_AXI.ARVALID = 1'b0;
    M_AXI.RREADY  = 1'b0;

    S0_AXI.ARREADY = 1'b0;
    S0_AXI.RID     = '0;
    S0_AXI.RDATA   = '0;
    S0_AXI.RRESP   = '0;
    S0_AXI.RLAST   = 1'b0;
    S0_AXI.RUSER   = '0;
    S0_AXI.RVALID  = 1'b0;

    S1_AXI.ARREADY = 1'b0;
    S1_AXI.RID     = '0;
    S1_AXI.RDATA   = '0;
    S1_AXI.RRESP   = '0;
    S1_AXI.RLAST   = 1'b0;
    S1_AXI.RUSER   = '0;
    S1_AXI.RVALID  = 1'b0;

    GRANT = 2'b00;
    BUSY  = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (S0_AXI.ARVALID || S1_AXI.ARVALID) begin
          grant_d = pick;
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        GRANT         = grant_q ? 2'b10 : 2'b01;
        // Fields pass straight through; the requester holds them stable until ARREADY.
        M_AXI.ARID    = grant_q ? S1_AXI.ARID    : S0_AXI.ARID;
        M_AXI.ARADDR  = grant_q ? S1_AXI.ARADDR  : S0_AXI.ARADDR;
        M_AXI.ARLEN   = grant_q ? S1_AXI.ARLEN   : S0_AXI.ARLEN;
        M_AXI.ARSIZE  = grant_q ? S1_AXI.ARSIZE  : S0_AXI.ARSIZE;
        M_AXI.ARBURST = grant_q ? S1_AXI.ARBURST : S0_AXI.ARBURST;
        M_AXI.ARLOCK  = grant_q ? S1_AXI.ARLOCK  : S0_AXI.ARLOCK;
        M_AXI.ARCACHE = grant_q ? S1_AXI.ARCACHE : S0_AXI.ARCACHE;
        M_AXI.ARPROT  = grant_q ? S1_AXI.ARPROT  : S0_AXI.ARPROT;
        M_AXI.ARQOS   = grant_q ? S1_AXI.ARQOS   : S0_AXI.ARQOS;
        M_AXI.ARUSER  = grant_q ? S1_AXI.ARUSER  : S0_AXI.ARUSER;
        M_AXI.ARVALID = ar_valid;
        if (grant_q) S1_AXI.ARREADY = M_AXI.ARREADY;
        else         S0_AXI.ARREADY = M_AXI.ARREADY;
        if (ar_valid && M_AXI.ARREADY) state_d = ST_DATA;
      end

      ST_DATA: begin
        GRANT        = grant_q ? 2'b10 : 2'b01;
        M_AXI.RREADY = r_ready;
        if (grant_q) begin
          S1_AXI.RID    = M_AXI.RID;
          S1_AXI.RDATA  = M_AXI.RDATA;
          S1_AXI.RRESP  = M_AXI.RRESP;
          S1_AXI.RLAST  = M_AXI.RLAST;
          S1_AXI.RUSER  = M_AXI.RUSER;
          S1_AXI.RVALID = M_AXI.RVALID;
        end else begin
          S0_AXI.RID    = M_AXI.RID;
          S0_AXI.RDATA  = M_AXI.RDATA;
          S0_AXI.RRESP  = M_AXI.RRESP;
          S0_AXI.RLAST  = M_AXI.RLAST;
          S0_AXI.RUSER  = M_AXI.RUSER;
          S0_AXI.RVALID = M_AXI.RVALID;
        end
        // Burst ends on the RLAST handshake; the next arbitration happens back in IDLE.
        if (M_AXI.RVALID && r_ready && M_AXI.RLAST) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [1:0] GRANT;
  logic       BUSY;
  int         tests  = 0;
  int         failed = 0;

  axi_rd_arbiter_if s0();
  axi_rd_arbiter_if s1();
  axi_rd_arbiter_if m();

  axi_rd_arbiter dut (
    .CLK    (CLK),
    .RST    (RST),
    .S0_AXI (s0),
    .S1_AXI (s1),
    .M_AXI  (m),
    .GRANT  (GRANT),
    .BUSY   (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #2;
  endtask

  task automatic clear_inputs;
    s0.ARID = '0; s0.ARADDR = '0; s0.ARLEN = '0; s0.ARSIZE = 3'd2; s0.ARBURST = 2'd1;
    s0.ARLOCK = '0; s0.ARCACHE = '0; s0.ARPROT = '0; s0.ARQOS = '0; s0.ARUSER = '0;
    s0.ARVALID = 1'b0; s0.RREADY = 1'b1;
    s1.ARID = '0; s1.ARADDR = '0; s1.ARLEN = '0; s1.ARSIZE = 3'd2; s1.ARBURST = 2'd1;
    s1.ARLOCK = '0; s1.ARCACHE = '0; s1.ARPROT = '0; s1.ARQOS = '0; s1.ARUSER = '0;
    s1.ARVALID = 1'b0; s1.RREADY = 1'b1;
    m.ARREADY = 1'b0; m.RID = '0; m.RDATA = '0; m.RRESP = '0; m.RLAST = 1'b0;
    m.RUSER = '0; m.RVALID = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"},   GRANT, 2'b00);
    chk({tag, "_busy"},    BUSY, 1'b0);
    chk({tag, "_marv"},    m.ARVALID, 1'b0);
    chk({tag, "_mrrdy"},   m.RREADY, 1'b0);
    chk({tag, "_s0arrdy"}, s0.ARREADY, 1'b0);
    chk({tag, "_s1arrdy"}, s1.ARREADY, 1'b0);
    chk({tag, "_s0rv"},    s0.RVALID, 1'b0);
    chk({tag, "_s1rv"},    s1.RVALID, 1'b0);
  endtask

  task automatic apply_reset;
    RST = 1'b0;
    clear_inputs();
    #1;
    chk_reset_vals("rst");
    tick();
    tick();
    RST = 1'b1;
  endtask

  // Called on the first ADDR cycle; completes the AR handshake and leaves the DUT in DATA.
  task automatic addr_phase(input bit o, input logic [31:0] a);
    chk("addr_grant",  GRANT, o ? 2'b10 : 2'b01);
    chk("addr_araddr", m.ARADDR, a);
    chk("addr_arvalid", m.ARVALID, 1'b1);
    m.ARREADY = 1'b1;
    #1;
    chk("addr_arready_own", o ? s1.ARREADY : s0.ARREADY, 1'b1);
    chk("addr_arready_oth", o ? s0.ARREADY : s1.ARREADY, 1'b0);
    tick();
    m.ARREADY = 1'b0;
  endtask

  // Beats first..first+cnt-1 of a total-beat burst, each accepted in one cycle.
  task automatic run_burst(input bit o, input int first, input int cnt, input int total,
                           input logic [31:0] base);
    for (int i = first; i < first + cnt; i++) begin
      m.RVALID = 1'b1;
      m.RDATA  = base + 32'(i);
      m.RUSER  = 4'(i);
      m.RLAST  = (i == total - 1);
      s0.RREADY = 1'b1;
      s1.RREADY = 1'b1;
      #1;
      chk("beat_rdata",   o ? s1.RDATA : s0.RDATA, base + 32'(i));
      chk("beat_ruser",   o ? s1.RUSER : s0.RUSER, 4'(i));
      chk("beat_rvalid",  o ? s1.RVALID : s0.RVALID, 1'b1);
      chk("beat_rlast",   o ? s1.RLAST : s0.RLAST, (i == total - 1));
      chk("beat_oth_rv",  o ? s0.RVALID : s1.RVALID, 1'b0);
      chk("beat_oth_rd",  o ? s0.RDATA : s1.RDATA, 32'h0);
      chk("beat_oth_arr", o ? s0.ARREADY : s1.ARREADY, 1'b0);
      chk("beat_mrready", m.RREADY, 1'b1);
      chk("beat_grant",   GRANT, o ? 2'b10 : 2'b01);
      tick();
    end
    m.RVALID = 1'b0;
    m.RLAST  = 1'b0;
  endtask

  bit exp_rr [3];

  initial begin
    // ---- reset state ----
    apply_reset();

    // ---- single S0 request, ARREADY after two ADDR cycles, 8 beats ----
    m.RVALID = 1'b1;                       // stray beat while IDLE must not leak
    s0.ARVALID = 1'b1; s0.ARADDR = 32'h0000_1000; s0.ARLEN = 8'd7;
    #1;
    chk("idle_busy", BUSY, 1'b0);
    chk("idle_s0arrdy", s0.ARREADY, 1'b0);
    chk("idle_marv", m.ARVALID, 1'b0);
    chk("idle_stray_rv", s0.RVALID, 1'b0);
    chk("idle_stray_rrdy", m.RREADY, 1'b0);
    tick();
    chk("addr_busy", BUSY, 1'b1);
    chk("addr_arlen", m.ARLEN, 8'd7);
    chk("addr_stray_rrdy", m.RREADY, 1'b0);
    m.RVALID = 1'b0;
    tick();
    chk("addr_wait_grant", GRANT, 2'b01);
    chk("addr_wait_s0arrdy", s0.ARREADY, 1'b0);
    tick();
    addr_phase(1'b0, 32'h0000_1000);
    s0.ARVALID = 1'b0;
    run_burst(1'b0, 0, 8, 8, 32'hA000_0000);
    chk("t1_idle_busy", BUSY, 1'b0);
    chk("t1_idle_grant", GRANT, 2'b00);

    // ---- tie from reset: S0 first, then S1 ----
    apply_reset();
    s0.ARVALID = 1'b1; s0.ARADDR = 32'h0000_1000; s0.ARLEN = 8'd0;
    s1.ARVALID = 1'b1; s1.ARADDR = 32'h0000_2000; s1.ARLEN = 8'd0;
    tick();
    addr_phase(1'b0, 32'h0000_1000);
    s0.ARVALID = 1'b0;
    run_burst(1'b0, 0, 1, 1, 32'hB000_0000);
    chk("t2_idle_grant", GRANT, 2'b00);
    chk("t2_idle_s1arrdy", s1.ARREADY, 1'b0);
    tick();
    addr_phase(1'b1, 32'h0000_2000);
    s1.ARVALID = 1'b0;
    run_burst(1'b1, 0, 1, 1, 32'hB100_0000);
    chk("t2_done_busy", BUSY, 1'b0);

    // ---- both requesting continuously (last owner was S1) ----
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    exp_rr[0] = 1'b1; exp_rr[1] = 1'b1; exp_rr[2] = 1'b1;
`else
    exp_rr[0] = 1'b0; exp_rr[1] = 1'b1; exp_rr[2] = 1'b0;
`endif
    s0.ARVALID = 1'b1; s0.ARADDR = 32'h0000_1000;
    s1.ARVALID = 1'b1; s1.ARADDR = 32'h0000_2000;
    for (int r = 0; r < 3; r++) begin
      tick();
      addr_phase(exp_rr[r], exp_rr[r] ? 32'h0000_2000 : 32'h0000_1000);
      run_burst(exp_rr[r], 0, 1, 1, 32'hC000_0000 + 32'(r << 8));
      chk("t3_idle_busy", BUSY, 1'b0);
    end
    s0.ARVALID = 1'b0;
    s1.ARVALID = 1'b0;
    tick();
    chk("t3_quiet_busy", BUSY, 1'b0);

    // ---- S0 RREADY stalled 3 cycles mid-burst ----
    s0.ARVALID = 1'b1; s0.ARADDR = 32'h0000_5000; s0.ARLEN = 8'd3;
    tick();
    addr_phase(1'b0, 32'h0000_5000);
    s0.ARVALID = 1'b0;
    run_burst(1'b0, 0, 1, 4, 32'hD000_0000);
    m.RVALID = 1'b1; m.RDATA = 32'hD000_0001; m.RUSER = 4'd1; m.RLAST = 1'b0;
    s0.RREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_mrready", m.RREADY, 1'b0);
      chk("stall_rdata", s0.RDATA, 32'hD000_0001);
      chk("stall_busy", BUSY, 1'b1);
      tick();
    end
    run_burst(1'b0, 1, 3, 4, 32'hD000_0000);
    chk("t4_idle_busy", BUSY, 1'b0);

    // ---- async reset during beat 3 of 8 ----
    s0.ARVALID = 1'b1; s0.ARADDR = 32'h0000_4000; s0.ARLEN = 8'd7;
    tick();
    addr_phase(1'b0, 32'h0000_4000);
    s0.ARVALID = 1'b0;
    run_burst(1'b0, 0, 3, 8, 32'hE000_0000);
    m.RVALID = 1'b1; m.RDATA = 32'hE000_0003;
    #1;
    chk("pre_rst_rvalid", s0.RVALID, 1'b1);
    RST = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    clear_inputs();
    tick();
    RST = 1'b1;
    s1.ARVALID = 1'b1; s1.ARADDR = 32'h0000_2000; s1.ARLEN = 8'd1;
    tick();
    addr_phase(1'b1, 32'h0000_2000);
    s1.ARVALID = 1'b0;
    run_burst(1'b1, 0, 2, 2, 32'hE100_0000);
    chk("t5_idle_busy", BUSY, 1'b0);

    // ---- S1 asks while S0 owns the data phase ----
    s0.ARVALID = 1'b1; s0.ARADDR = 32'h0000_6000; s0.ARLEN = 8'd1;
    tick();
    addr_phase(1'b0, 32'h0000_6000);
    s0.ARVALID = 1'b0;
    s1.ARVALID = 1'b1; s1.ARADDR = 32'h0000_7000; s1.ARLEN = 8'd0;
    run_burst(1'b0, 0, 2, 2, 32'hF000_0000);
    chk("t6_idle_busy", BUSY, 1'b0);
    chk("t6_idle_s1arrdy", s1.ARREADY, 1'b0);
    tick();
    addr_phase(1'b1, 32'h0000_7000);
    s1.ARVALID = 1'b0;
    run_burst(1'b1, 0, 1, 1, 32'hF100_0000);
    chk("t6_done_busy", BUSY, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares one AXI4 read master port between two read requesters: S0 = instruction fetch cache, S1 = data load cache.
- It sits between the core's cache read engines and the top-level M_AXI read interface.
- One transaction is outstanding at a time. The AR issue and the full R burst are locked to the granted requester until RLAST.
- Default policy is round-robin. It is replaceable by fixed priority at compile time.

Parameters:
C_M_AXI_THREAD_ID_WIDTH, 1, ARID/RID width
C_M_AXI_ADDR_WIDTH, 32, ARADDR width
C_M_AXI_DATA_WIDTH, 32, RDATA width
C_M_AXI_ARUSER_WIDTH, 1, ARUSER width
C_M_AXI_RUSER_WIDTH, 4, RUSER width

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  asynchronous, active-low reset (0 = reset)
S0_AXI_AR{ID,ADDR,LEN,SIZE,BURST,LOCK,CACHE,PROT,QOS,USER}  in  per AXI widths (LEN 8, SIZE 3, BURST 2, LOCK 2, CACHE 4, PROT 3, QOS 4)  requester 0 AR fields
S0_AXI_ARVALID  in  1  / S0_AXI_ARREADY  out  1
S0_AXI_R{ID,DATA,RESP,LAST,USER,VALID}  out  per AXI widths  requester 0 R channel
S0_AXI_RREADY  in  1
S1_AXI_*  same set as S0 for requester 1
M_AXI_AR{ID,ADDR,LEN,SIZE,BURST,LOCK,CACHE,PROT,QOS,USER,VALID}  out  per AXI widths  shared master AR
M_AXI_ARREADY  in  1
M_AXI_R{ID,DATA,RESP,LAST,USER,VALID}  in  per AXI widths  shared master R
M_AXI_RREADY  out  1
GRANT  out  2  one-hot current owner; 00 when idle
BUSY  out  1  1 while state != IDLE

Behaviour:
- State machine: IDLE -> ADDR -> DATA -> IDLE. Registers: state, grant (1 bit), last_grant (1 bit).
- Reset (RST=0, async): state=IDLE, grant=0, last_grant=1 (so S0 wins the first tie), GRANT=00, BUSY=0, M_AXI_ARVALID=0, M_AXI_RREADY=0, S*_ARREADY=0, S*_RVALID=0.
- IDLE:
  - All ARREADY=0 and M_AXI_ARVALID=0.
  - If any S*_ARVALID=1: grant <= arbiter pick; state <= ADDR.
  - Arbitration costs one cycle.
- Round-robin pick:
  - If exactly one requests, pick it.
  - If both request, pick !last_grant.
- ADDR:
  - M_AXI_AR* = S[grant]_AXI_AR*, with M_AXI_ARVALID = S[grant]_ARVALID.
  - S[grant]_ARREADY = M_AXI_ARREADY. Non-granted ARREADY=0.
  - On the M_AXI_ARVALID & M_AXI_ARREADY handshake: state <= DATA.
  - AR fields are muxed combinationally, not re-registered. The requester must hold them stable per AXI.
- DATA:
  - S[grant]_R* = M_AXI_R*, S[grant]_RVALID = M_AXI_RVALID, M_AXI_RREADY = S[grant]_RREADY.
  - Non-granted RVALID=0. Non-granted RDATA/RID/etc. are driven 0.
  - On RVALID & RREADY & RLAST: state <= IDLE, last_grant <= grant.
  - New AR requests wait in IDLE, so a new request sees at least 1 dead cycle after RLAST.
- GRANT is one-hot of grant in ADDR and DATA, and 00 in IDLE.
- Simultaneous events:
  - A requester deasserting ARVALID in ADDR is an AXI violation. The block stays in ADDR; no recovery.
  - An ARVALID from the non-granted requester during ADDR/DATA is held off (ARREADY=0) until the next IDLE.
- M_AXI_RVALID in IDLE/ADDR is unexpected. It is not forwarded, and M_AXI_RREADY=0.
- Reset mid-burst: returns to IDLE immediately; remaining beats are not tracked. The bench applies reset to the slave as well.
- No ID remapping: ARID/RID pass through unchanged.

Optional Feature:
- Macro: AXI_RD_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, S1 (data) always beats S0 on a tie. last_grant is unused; tie-breaking no longer depends on history.
- Undefined: round-robin as above.

Decomposition:
- Package axi_rd_arb_pkg: state encodings (IDLE=2'd0, ADDR=2'd1, DATA=2'd2), AXI field width localparams (LEN 8, SIZE 3, BURST 2, LOCK 2, CACHE 4, PROT 3, QOS 4, RESP 2).
- Sub-module rr_arbiter_2: inputs req[1:0] and last_grant; output the pick. The fixed-priority macro is handled inside it.

Test Plan:
- Single S0 request ARADDR=0x0000_1000, ARLEN=7, slave ARREADY after 2 cycles -> M_AXI_ARADDR=0x1000 and GRANT=01 from ADDR entry; 8 beats reach S0 only; S1_RVALID stays 0; IDLE one cycle after the RLAST handshake.
- S0 and S1 request ARVALID in the same cycle from reset -> S0 granted first. After its RLAST, S1 is granted; M_AXI_ARADDR switches to S1's address (0x2000).
- S0 issues continuous back-to-back requests with S1 pending -> grants alternate S0,S1,S0. With AXI_RD_ARB_FIXED_PRIO_EN defined, S1 wins every tie.
- S0 RREADY held 0 for 3 cycles mid-burst -> M_AXI_RREADY=0 for those cycles; beat data unchanged at S0 when accepted; no beats lost.
- RST pulled to 0 asynchronously during DATA beat 3 of 8 -> all outputs at reset values without waiting for CLK; BUSY=0. After release, a new S1 request is granted normally.
- S1 ARVALID while S0 is in DATA -> S1_ARREADY stays 0 throughout; S1 is granted in the cycle after return to IDLE.
